// File: rtl/fpu_acc_driver.sv
// fpu_acc_driver: accumulates LEN binary32 terms through an external
// stb/ack single-precision adder and returns the final sum over a
// valid/ready port. The first term is loaded directly into the running
// sum, so the adder performs exactly LEN-1 additions per batch.
module fpu_acc_driver #(
    parameter int LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_a_stb,
    input  logic        add_a_ack,
    output logic        add_b_stb,
    input  logic        add_b_ack,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        add_z_ack,
    output logic [31:0] out_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {LOAD, SEND, WAIT_Z, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     term_q, term_d;
    logic            in_ready_q, in_ready_d;
    logic            a_stb_q, a_stb_d;
    logic            b_stb_q, b_stb_d;
    logic            z_ack_q, z_ack_d;
    logic            out_valid_q, out_valid_d;

    logic            in_fire, a_fire, b_fire, z_fire, out_fire;
    logic            last_term, batch_full;

    assign in_fire    = in_valid && in_ready_q;
    assign a_fire     = a_stb_q && add_a_ack;
    assign b_fire     = b_stb_q && add_b_ack;
    assign z_fire     = add_z_stb && z_ack_q;
    assign out_fire   = out_valid_q && out_ready;
    // Accepting a term while count==LEN-1 completes the batch's input.
    assign last_term  = (count_q == CW'(LEN - 1));
    assign batch_full = (count_q == CW'(LEN));

    // Next-state and registered-output logic for the accumulation FSM.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_d       = sum_q;
        term_d      = term_q;
        in_ready_d  = in_ready_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = z_ack_q;
        out_valid_d = out_valid_q;
        case (state_q)
            LOAD: begin
                // in_ready is registered, so it rises on the first clock
                // after reset release and stays high while waiting.
                in_ready_d = 1'b1;
                if (in_fire) begin
                    count_d = count_q + 1'b1;
                    if (count_q == '0) begin
                        // First term bypasses the adder entirely.
                        sum_d = in_data;
                        if (last_term) begin
                            state_d     = DONE;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end
                    end else begin
                        term_d     = in_data;
                        state_d    = SEND;
                        in_ready_d = 1'b0;
                        a_stb_d    = 1'b1;
                        b_stb_d    = 1'b1;
                    end
                end
            end
            SEND: begin
                // Each strobe retires on its own ack; a dropped strobe
                // means that operand has already transferred.
                if (a_fire) a_stb_d = 1'b0;
                if (b_fire) b_stb_d = 1'b0;
                if ((!a_stb_q || add_a_ack) && (!b_stb_q || add_b_ack)) begin
                    state_d = WAIT_Z;
                    z_ack_d = 1'b1;
                end
            end
            WAIT_Z: begin
                if (z_fire) begin
                    sum_d   = add_z;
                    z_ack_d = 1'b0;
                    if (batch_full) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = LOAD;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and output registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            count_q     <= '0;
            sum_q       <= '0;
            term_q      <= '0;
            in_ready_q  <= 1'b0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            term_q      <= term_d;
            in_ready_q  <= in_ready_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = sum_q;
    assign add_b     = term_q;
    assign add_a_stb = a_stb_q;
    assign add_b_stb = b_stb_q;
    assign add_z_ack = z_ack_q;
    assign out_sum   = sum_q;
    assign out_valid = out_valid_q;
    assign busy      = !((state_q == LOAD) && (count_q == '0));

endmodule

// File: tb/tb_fpu_acc_driver.sv
// Bench for fpu_acc_driver: a LEN=4 instance driven against a behavioural
// stb/ack adder with programmable ack/result delays, plus a LEN=1 instance
// whose adder port is left idle.
module tb_fpu_acc_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LEN=4 instance signals
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] add_a, add_b, add_z;
    logic        add_a_stb, add_b_stb, add_z_ack;
    logic        add_a_ack, add_b_ack, add_z_stb;
    logic [31:0] out_sum;
    logic        out_valid, out_ready = 1'b0, busy;

    // LEN=1 instance signals
    logic [31:0] in_data1 = '0;
    logic        in_valid1 = 1'b0, in_ready1;
    logic [31:0] add_a1, add_b1;
    logic        add_a_stb1, add_b_stb1, add_z_ack1;
    logic [31:0] out_sum1;
    logic        out_valid1, out_ready1 = 1'b0, busy1;

    int checks = 0;
    int passes = 0;

    fpu_acc_driver #(.LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b),
        .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
        .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    fpu_acc_driver #(.LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .add_a(add_a1), .add_b(add_b1),
        .add_a_stb(add_a_stb1), .add_a_ack(1'b0),
        .add_b_stb(add_b_stb1), .add_b_ack(1'b0),
        .add_z(32'h0), .add_z_stb(1'b0), .add_z_ack(add_z_ack1),
        .out_sum(out_sum1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1)
    );

    // binary32 <-> real, normal numbers and zero only (all bench values are
    // small integers or short fractions, so conversions are exact).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural adder: acks each operand a_dly/b_dly cycles after its
    // strobe appears, then offers the sum z_dly cycles after both arrive.
    int a_dly = 0, b_dly = 0, z_dly = 1;
    int ztx = 0;
    logic [31:0] m_opa, m_opb;
    bit  m_ha, m_hb;
    int  m_ca, m_cb, m_cz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0; add_z <= '0;
            m_ha <= 1'b0; m_hb <= 1'b0; m_ca <= 0; m_cb <= 0; m_cz <= 0;
        end else begin
            if (add_a_stb && add_a_ack) begin
                m_opa <= add_a; m_ha <= 1'b1; add_a_ack <= 1'b0; m_ca <= 0;
            end else if (add_a_stb && !m_ha && !add_a_ack) begin
                if (m_ca >= a_dly) add_a_ack <= 1'b1; else m_ca <= m_ca + 1;
            end
            if (add_b_stb && add_b_ack) begin
                m_opb <= add_b; m_hb <= 1'b1; add_b_ack <= 1'b0; m_cb <= 0;
            end else if (add_b_stb && !m_hb && !add_b_ack) begin
                if (m_cb >= b_dly) add_b_ack <= 1'b1; else m_cb <= m_cb + 1;
            end
            if (add_z_stb && add_z_ack) begin
                add_z_stb <= 1'b0; m_ha <= 1'b0; m_hb <= 1'b0; m_cz <= 0; ztx <= ztx + 1;
            end else if (m_ha && m_hb && !add_z_stb) begin
                if (m_cz >= z_dly) begin
                    add_z_stb <= 1'b1;
                    add_z     <= r2f(f2r(m_opa) + f2r(m_opb));
                end else m_cz <= m_cz + 1;
            end
        end
    end

    // Protocol monitor: strobe/ack exclusivity, operand stability while a
    // strobe waits, and counters used by the scenario tasks.
    int  mon_err = 0, a_rises = 0, skew_cyc = 0, len1_stb = 0;
    bit  mon_bad;
    logic p_as, p_bs, p_aack, p_back;
    logic [31:0] p_a, p_b;

    always @(posedge clk) begin
        if (rst_n) begin
            mon_bad = (add_z_ack && (add_a_stb || add_b_stb))
                   || (in_ready && (add_a_stb || add_b_stb || add_z_ack || out_valid))
                   || (p_as && !p_aack && add_a_stb && add_a !== p_a)
                   || (p_bs && !p_back && add_b_stb && add_b !== p_b);
            if (mon_bad) mon_err <= mon_err + 1;
            if (add_a_stb && !p_as) a_rises <= a_rises + 1;
            if (add_a_stb && !add_b_stb) skew_cyc <= skew_cyc + 1;
            if (add_a_stb1 || add_b_stb1 || add_z_ack1) len1_stb <= len1_stb + 1;
        end
        p_as <= add_a_stb; p_bs <= add_b_stb;
        p_aack <= add_a_ack; p_back <= add_b_ack;
        p_a <= add_a; p_b <= add_b;
    end

    // Offer one term and return #1 after the edge that transferred it.
    task automatic put_term(input logic [31:0] d, input bit chk_gap);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++;
            $display("FAIL put_term timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chk_gap) begin
            checks++;
            if (in_ready !== 1'b0) $display("FAIL in_ready_gap: got %b required 0", in_ready);
            else passes++;
        end
    endtask

    // Wait for out_valid, hold out_ready low for 'hold' cycles while
    // checking stability, then complete the handshake.
    task automatic get_result(input int hold, output logic [31:0] s, output bit ok);
        int n;
        n = 0; ok = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        if (!out_valid) begin
            checks++;
            $display("FAIL get_result timeout: out_valid=%b required 1", out_valid);
            ok = 1'b0;
        end
        s = out_sum;
        repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== s || in_ready !== 1'b0) ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_batch(input logic [31:0] t [4], input int hold, output logic [31:0] s);
        bit ok;
        for (int i = 0; i < 4; i++) put_term(t[i], i > 0);
        get_result(hold, s, ok);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({in_ready, add_a_stb, add_b_stb, add_z_ack, out_valid, busy} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 000000",
                     {in_ready, add_a_stb, add_b_stb, add_z_ack, out_valid, busy});
        else passes++;
        checks++;
        if ({add_a, add_b, out_sum} !== 96'h0)
            $display("FAIL reset_data: got %h %h %h required zeros", add_a, add_b, out_sum);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1)
            $display("FAIL reset_release_ready: got %b/%b required 1/1", in_ready, in_ready1);
        else passes++;
    endtask

    task automatic test_vec(input logic [31:0] t [4], input logic [31:0] exp_s, input string nm);
        logic [31:0] s;
        int z0, r0;
        z0 = ztx; r0 = a_rises;
        run_batch(t, 0, s);
        checks++;
        if (s !== exp_s) $display("FAIL %s sum: got %h required %h", nm, s, exp_s);
        else passes++;
        checks++;
        if (ztx - z0 != 3 || a_rises - r0 != 3)
            $display("FAIL %s adder_txns: got %0d/%0d required 3/3", nm, ztx - z0, a_rises - r0);
        else passes++;
    endtask

    task automatic test_skew;
        logic [31:0] t [4];
        logic [31:0] s;
        int sk0, e0;
        t = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        a_dly = 5; b_dly = 2; z_dly = 1;
        sk0 = skew_cyc; e0 = mon_err;
        run_batch(t, 0, s);
        checks++;
        if (s !== 32'h41200000) $display("FAIL skew sum: got %h required 41200000", s);
        else passes++;
        checks++;
        if (skew_cyc - sk0 < 3)
            $display("FAIL skew b_drop_before_a: got %0d cycles required >=3", skew_cyc - sk0);
        else passes++;
        checks++;
        if (mon_err != e0) $display("FAIL skew protocol: got %0d errors required 0", mon_err - e0);
        else passes++;
        a_dly = 0; b_dly = 0;
    endtask

    task automatic test_backpressure;
        logic [31:0] s;
        bit ok;
        z_dly = 2;
        put_term(32'h40000000, 0);
        put_term(32'h40000000, 1);
        put_term(32'h40000000, 1);
        put_term(32'h40000000, 1);
        // First term of the next batch is offered early; it must wait.
        in_data = 32'h41000000; in_valid = 1'b1;
        get_result(20, s, ok);
        checks++;
        if (!ok) $display("FAIL backpressure_hold: stable=%b required 1", ok);
        else passes++;
        checks++;
        if (s !== 32'h41000000) $display("FAIL backpressure sum: got %h required 41000000", s);
        else passes++;
        put_term(32'h41000000, 0);
        put_term(32'h3F800000, 1);
        put_term(32'h3F800000, 1);
        put_term(32'h3F800000, 1);
        get_result(0, s, ok);
        checks++;
        if (s !== 32'h41300000) $display("FAIL backpressure next_batch: got %h required 41300000", s);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] t [4];
        logic [31:0] s;
        int z0, n;
        z_dly = 8; z0 = ztx; n = 0;
        put_term(32'h3F800000, 0);
        put_term(32'h40000000, 1);
        put_term(32'h40400000, 1);
        @(negedge clk);
        while (!add_z_ack && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!add_z_ack || ztx - z0 != 1)
            $display("FAIL reset_mid reach_wait_z: ack=%b txns=%0d required 1/1", add_z_ack, ztx - z0);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, add_a_stb, add_b_stb, add_z_ack, out_valid, busy} !== 6'b0
            || {add_a, add_b, out_sum} !== 96'h0)
            $display("FAIL reset_mid async_clear: ctrl=%b a=%h b=%h sum=%h required zeros",
                     {in_ready, add_a_stb, add_b_stb, add_z_ack, out_valid, busy}, add_a, add_b, out_sum);
        else passes++;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        z_dly = 1;
        t = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        run_batch(t, 0, s);
        checks++;
        if (s !== 32'h40800000) $display("FAIL reset_mid fresh_batch: got %h required 40800000", s);
        else passes++;
    endtask

    task automatic test_random;
        logic [31:0] t [4];
        logic [31:0] s, exp_s;
        real acc;
        bit ok;
        int e0;
        e0 = mon_err;
        for (int b = 0; b < 6; b++) begin
            a_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4); z_dly = $urandom_range(0, 4);
            acc = 0.0;
            for (int i = 0; i < 4; i++) begin
                t[i] = r2f(real'(int'($urandom_range(0, 2000)) - 1000));
                acc += f2r(t[i]);
            end
            exp_s = r2f(acc);
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 put_term(t[i], i > 0);
            end
            get_result($urandom_range(0, 5), s, ok);
            checks++;
            if (s !== exp_s || !ok)
                $display("FAIL random batch%0d: got %h stable=%b required %h stable=1", b, s, ok, exp_s);
            else passes++;
        end
        checks++;
        if (mon_err != e0) $display("FAIL random protocol: got %0d errors required 0", mon_err - e0);
        else passes++;
        a_dly = 0; b_dly = 0; z_dly = 1;
    endtask

    task automatic test_len1;
        int n;
        n = 0;
        in_data1 = 32'h40A00000; in_valid1 = 1'b1;
        @(negedge clk);
        while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== 32'h40A00000 || in_ready1 !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL len1 result: valid=%b sum=%h ready=%b busy=%b required 1 40a00000 0 1",
                     out_valid1, out_sum1, in_ready1, busy1);
        else passes++;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL len1 release: valid=%b ready=%b busy=%b required 0 1 0", out_valid1, in_ready1, busy1);
        else passes++;
        checks++;
        if (len1_stb != 0) $display("FAIL len1 adder_strobes: got %0d required 0", len1_stb);
        else passes++;
    endtask

    initial begin
        logic [31:0] v1 [4];
        logic [31:0] v2 [4];
        v1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        v2 = '{32'h3FC00000, 32'h40200000, 32'hC0500000, 32'h3FE00000};
        test_reset;
        test_vec(v1, 32'h41200000, "vec_10");
        test_vec(v2, 32'h40200000, "vec_2p5");
        test_skew;
        test_backpressure;
        test_reset_mid;
        test_random;
        test_len1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fpu_acc_driver.md
# fpu_acc_driver

Initiator for the single-precision adder's stb/ack handshake. Accepts a stream of LEN IEEE-754 binary32 terms over a valid/ready port and issues LEN-1 adder transactions of the form running_sum + term. It returns the final sum on a valid/ready output port. It sits between the matrix datapath (products in) and one shared fpu_adder instance, and forms the accumulation stage of a dot product.

## Interface
- LEN, 8, number of terms per accumulation (>=1); counter width $clog2(LEN+1)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  32  term (binary32)
- in_valid  in  1  term offered
- in_ready  out  1  term accepted when in_valid && in_ready
- add_a  out  32  adder operand A (running sum)
- add_b  out  32  adder operand B (current term)
- add_a_stb  out  1  operand A offered to adder
- add_a_ack  in  1  adder took A (transfer when add_a_stb && add_a_ack)
- add_b_stb  out  1  operand B offered to adder
- add_b_ack  in  1  adder took B
- add_z  in  32  adder result
- add_z_stb  in  1  adder result offered
- add_z_ack  out  1  result taken when add_z_stb && add_z_ack
- out_sum  out  32  final sum
- out_valid  out  1  out_sum valid, held until out_ready
- out_ready  in  1  consumer accepts
- busy  out  1  high in any state other than LOAD with count==0

## Operation
- States: LOAD, SEND, WAIT_Z, DONE.
- LOAD: in_ready=1. On transfer:
  - If count==0: sum<=in_data and count<=1. The first term bypasses the adder, so there is no 0+x signed-zero issue.
  - Otherwise: term<=in_data, count<=count+1, go to SEND.
  - If the accepted term makes count==LEN (including LEN=1), go to DONE when no addition is pending. Otherwise go to SEND after the addition is set up.
- SEND: add_a=sum and add_b=term, held stable while the respective stb is high. add_a_stb and add_b_stb rise together on entry. Each strobe drops the cycle after its own ack transfer and is independent of the other. When both have transferred (same or different cycles), go to WAIT_Z.
- WAIT_Z: add_z_ack=1. On add_z_stb && add_z_ack: sum<=add_z and add_z_ack drops next cycle. Then go to DONE if count==LEN, else LOAD.
- DONE: out_valid=1 and out_sum=sum, stable until out_ready. On out_valid && out_ready: count<=0, go to LOAD.
- No FP interpretation in this block. NaN, inf and denormal handling belongs to the adder, and results pass through bit-exact.
- in_ready is low in SEND, WAIT_Z and DONE. There is no overlap between batches.
- Adder strobes never assert outside SEND. add_z_ack never asserts outside WAIT_Z.

## Timing
- Reset (async, rst_n low): state=LOAD, count=0, sum=0. in_ready=0 while rst_n low, then 1 from the first clock after release. All stb/ack/valid outputs are 0, out_sum=0, add_a=add_b=0, busy=0.
- Reset mid-operation (any state): outputs clear immediately with no clock. Any partial sum is discarded. The adder shares rst_n and is assumed reset with this block.
- Per addition: 1 cycle LOAD transfer, then SEND (>=1 cycle, set by ack latency), then WAIT_Z (adder latency), then 1 capture cycle.
- Best-case batch latency, from the last term transfer to out_valid: SEND + WAIT_Z + 1 cycles.
- out_valid rises the cycle after the capture of the final add_z, or the cycle after the transfer of the single term when LEN=1.
- Simultaneous a/b acks in the same cycle: both strobes drop next cycle, and WAIT_Z is entered next cycle.
- An add_z_stb arriving before WAIT_Z is ignored: add_z_ack stays low and the adder holds its result.

## Test plan
- LEN=4, terms 3F800000, 40000000, 40400000, 40800000 -> out_sum=41200000 (10.0); exactly 3 adder transactions; in_ready low between terms.
- LEN=4, terms 3FC00000, 40200000, C0500000, 3FE00000 -> out_sum=40200000 (2.5).
- Adder model delays add_a_ack 5 cycles and add_b_ack 2 cycles -> add_b_stb drops after its ack while add_a_stb and add_a stay stable. No add_z_ack before both transfers. Result unchanged.
- out_ready held low 20 cycles after out_valid -> out_valid and out_sum stable, in_ready=0. The next batch is accepted only after the out_ready handshake.
- rst_n pulsed low during WAIT_Z of the second addition -> all outputs 0 asynchronously. After release, a fresh batch 1.0 ×4 yields 40800000.
- LEN=1, term 40A00000 -> out_sum=40A00000, zero adder strobes.
